// File: rtl/sdram_pkg.sv
// sdram_pkg: shared types and helpers for the SDRAM device responder.
//   cmd_e       - decoded pin command
//   cmd_decode  - {cs,ras,cas,we} -> cmd_e
//   bl_decode   - mode addr[2:0] -> burst mask (BL-1) plus legality
//   cl_decode   - mode addr[6:4] -> CAS-latency-3 flag plus legality
//   ERR_*       - sticky error codes
package sdram_pkg;

   typedef enum logic [2:0] {
      CMD_NOP, CMD_ACT, CMD_RD, CMD_WR, CMD_PRE, CMD_REF, CMD_MRS, CMD_BST
   } cmd_e;

   localparam logic [2:0] ERR_NONE     = 3'd0;
   localparam logic [2:0] ERR_CLOSED   = 3'd1;
   localparam logic [2:0] ERR_ACT_OPEN = 3'd2;
   localparam logic [2:0] ERR_NO_MODE  = 3'd3;
   localparam logic [2:0] ERR_MODE     = 3'd4;
   localparam logic [2:0] ERR_REF_OPEN = 3'd5;

   typedef struct packed {
      logic       ok;
      logic [2:0] mask;   // BL-1, also the in-block column wrap mask
   } bl_t;

   typedef struct packed {
      logic ok;
      logic is3;          // 1: CL3, 0: CL2
   } cl_t;

   function automatic cmd_e cmd_decode(input logic [3:0] pins);
      cmd_e c;
      c = CMD_NOP;
      if (!pins[3]) begin
         case (pins[2:0])
            3'b011:  c = CMD_ACT;
            3'b101:  c = CMD_RD;
            3'b100:  c = CMD_WR;
            3'b010:  c = CMD_PRE;
            3'b001:  c = CMD_REF;
            3'b000:  c = CMD_MRS;
            3'b110:  c = CMD_BST;
            default: c = CMD_NOP;
         endcase
      end
      return c;
   endfunction

   function automatic bl_t bl_decode(input logic [2:0] code);
      bl_t b;
      case (code)
         3'd0:    b = '{ok: 1'b1, mask: 3'd0};
         3'd1:    b = '{ok: 1'b1, mask: 3'd1};
         3'd2:    b = '{ok: 1'b1, mask: 3'd3};
         3'd3:    b = '{ok: 1'b1, mask: 3'd7};
         default: b = '{ok: 1'b0, mask: 3'd0};
      endcase
      return b;
   endfunction

   function automatic cl_t cl_decode(input logic [2:0] code);
      cl_t c;
      case (code)
         3'd2:    c = '{ok: 1'b1, is3: 1'b0};
         3'd3:    c = '{ok: 1'b1, is3: 1'b1};
         default: c = '{ok: 1'b0, is3: 1'b1};
      endcase
      return c;
   endfunction

endpackage

// File: rtl/sdram_resp_ram.sv
// sdram_resp_ram: single-port backing RAM, 2^AW x DW, per-byte write enables,
// registered (1-cycle) read. Contents are not reset.
//   clk_i   - clock
//   en_i    - enable; low holds both memory and read register
//   we_i    - write strobe (read otherwise)
//   be_i    - byte enables, bit 0 = low byte
//   addr_i  - word address
//   wdata_i - write data
//   rdata_o - read data, valid the cycle after a read
module sdram_resp_ram #(
   parameter int AW = 12,
   parameter int DW = 16
) (
   input  logic            clk_i,
   input  logic            en_i,
   input  logic            we_i,
   input  logic [DW/8-1:0] be_i,
   input  logic [AW-1:0]   addr_i,
   input  logic [DW-1:0]   wdata_i,
   output logic [DW-1:0]   rdata_o
);

   logic [DW-1:0] mem_q [2**AW];

   always_ff @(posedge clk_i) begin
      if (en_i) begin
         if (we_i) begin
            for (int b = 0; b < DW/8; b++)
               if (be_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
         end else begin
            rdata_o <= mem_q[addr_i];
         end
      end
   end

endmodule

// File: rtl/sdram_responder.sv
// sdram_responder: SDRAM device model answering the controller pin interface.
// Decodes commands, tracks per-bank open rows and the mode register, runs the
// read/write burst engine against sdram_resp_ram and returns read data with
// the programmed CAS latency. Protocol violations latch a sticky error code.
//   sdram_clk_i, rst_n_i      - clock, async active-low reset
//   sd_cke_i                  - clock enable; low freezes all state
//   sd_cs/ras/cas/we_i        - active-low command pins
//   sd_bs_i, sd_addr_i        - bank select, row/column/mode value
//   sd_dqml_i, sd_dqmh_i      - byte masks
//   sd_dq_i / sd_dq_o         - write data in / read data out
//   sd_dq_oe_o                - per-byte read output enable
//   err_o, err_code_o         - sticky error flag and first error code
module sdram_responder
   import sdram_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 13,
   parameter int COL_W  = 9,
   parameter int MEM_AW = 12
) (
   input  logic              sdram_clk_i,
   input  logic              rst_n_i,
   input  logic              sd_cke_i,
   input  logic              sd_cs_i,
   input  logic              sd_ras_i,
   input  logic              sd_cas_i,
   input  logic              sd_we_i,
   input  logic [1:0]        sd_bs_i,
   input  logic [ADDR_W-1:0] sd_addr_i,
   input  logic              sd_dqml_i,
   input  logic              sd_dqmh_i,
   input  logic [DATA_W-1:0] sd_dq_i,
   output logic [DATA_W-1:0] sd_dq_o,
   output logic [1:0]        sd_dq_oe_o,
   output logic              err_o,
   output logic [2:0]        err_code_o
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RD   = 2'd1;
   localparam logic [1:0] S_WR   = 2'd2;
   localparam int STAGES = 2;

   cmd_e cmd;
   bl_t  bl;
   cl_t  cl;
   logic [1:0] dqm;
   assign cmd = cmd_decode({sd_cs_i, sd_ras_i, sd_cas_i, sd_we_i});
   assign bl  = bl_decode(sd_addr_i[2:0]);
   assign cl  = cl_decode(sd_addr_i[6:4]);
   assign dqm = {sd_dqmh_i, sd_dqml_i};

   // bank / mode / error state
   logic [3:0]             open_q, open_d;
   logic [3:0][ADDR_W-1:0] row_q, row_d;
   logic                   mode_ld_q, mode_ld_d;
   logic [2:0]             bl_mask_q, bl_mask_d;
   logic                   cl3_q, cl3_d;
   logic                   err_q, err_d;
   logic [2:0]             code_q, code_d, ecode;

   // burst engine: start column, next beat index, latched burst length
   logic [1:0]       st_q, st_d, bank_q, bank_d;
   logic [COL_W-1:0] col_q, col_d;
   logic [2:0]       idx_q, idx_d, bmask_q, bmask_d;
   logic             ap_q, ap_d;

   // read return pipeline; stage 0 data lives in the RAM output register
   logic [STAGES:0]             vld_pipe;
   logic [STAGES:1][DATA_W-1:0] dat_q;
   logic [1:0][1:0]             dqm_q;

   logic rw_cmd, rw_ok, stop, cont, acc, acc_rd, rd_beat;
   logic [1:0]        acc_bank;
   logic [COL_W-1:0]  acc_col;
   logic [2:0]        lo_col;
   logic [DATA_W-1:0] ram_rdata;

   assign rw_cmd = (cmd == CMD_RD) || (cmd == CMD_WR);
   assign rw_ok  = rw_cmd && mode_ld_q && open_q[sd_bs_i];
   // any of these ends a running burst on this edge, with no beat taken
   assign stop   = rw_cmd || (cmd == CMD_BST) ||
                   ((cmd == CMD_PRE) && (sd_addr_i[10] || (sd_bs_i == bank_q)));
   assign cont   = (st_q != S_IDLE) && !stop;
   assign acc    = rw_ok || cont;
   assign acc_rd = rw_ok ? (cmd == CMD_RD) : (st_q == S_RD);
   assign rd_beat = acc && acc_rd;

   // column steps within the aligned BL block, wrapping at its end
   assign lo_col   = (col_q[2:0] & ~bmask_q) | ((col_q[2:0] + idx_q) & bmask_q);
   assign acc_bank = rw_ok ? sd_bs_i : bank_q;
   assign acc_col  = rw_ok ? sd_addr_i[COL_W-1:0] : {col_q[COL_W-1:3], lo_col};

   sdram_resp_ram #(.AW(MEM_AW), .DW(DATA_W)) u_ram (
      .clk_i   (sdram_clk_i),
      .en_i    (sd_cke_i),
      .we_i    (acc && !acc_rd),
      .be_i    (~dqm),
      .addr_i  (MEM_AW'({acc_bank, row_q[acc_bank], acc_col})),
      .wdata_i (sd_dq_i),
      .rdata_o (ram_rdata)
   );

   always_comb begin
      st_d = st_q; bank_d = bank_q; col_d = col_q; idx_d = idx_q;
      bmask_d = bmask_q; ap_d = ap_q; open_d = open_q; row_d = row_q;
      mode_ld_d = mode_ld_q; bl_mask_d = bl_mask_q; cl3_d = cl3_q;
      err_d = err_q; code_d = code_q; ecode = ERR_NONE;
      if (cont) begin
         if (idx_q == bmask_q) begin
            st_d = S_IDLE;
            if (ap_q) open_d[bank_q] = 1'b0;
         end else begin
            idx_d = idx_q + 3'd1;
         end
      end else if (stop) begin
         st_d = S_IDLE;
      end
      case (cmd)
         CMD_ACT:
            if (open_q[sd_bs_i]) ecode = ERR_ACT_OPEN;
            else begin
               open_d[sd_bs_i] = 1'b1;
               row_d[sd_bs_i]  = sd_addr_i;
            end
         CMD_RD, CMD_WR:
            if (!mode_ld_q)             ecode = ERR_NO_MODE;
            else if (!open_q[sd_bs_i])  ecode = ERR_CLOSED;
            else begin
               bank_d  = sd_bs_i;
               col_d   = sd_addr_i[COL_W-1:0];
               idx_d   = 3'd1;
               bmask_d = bl_mask_q;
               ap_d    = sd_addr_i[10];
               if (bl_mask_q == 3'd0) begin
                  st_d = S_IDLE;
                  if (sd_addr_i[10]) open_d[sd_bs_i] = 1'b0;
               end else begin
                  st_d = (cmd == CMD_RD) ? S_RD : S_WR;
               end
            end
         CMD_PRE:
            if (sd_addr_i[10]) open_d = '0;
            else               open_d[sd_bs_i] = 1'b0;
         CMD_REF:
            if (|open_q) ecode = ERR_REF_OPEN;
         CMD_MRS: begin
            mode_ld_d = 1'b1;
            bl_mask_d = bl.mask;
            cl3_d     = cl.is3;
            if (!bl.ok || !cl.ok) ecode = ERR_MODE;
         end
         default: ;
      endcase
      if ((ecode != ERR_NONE) && !err_q) begin
         err_d  = 1'b1;
         code_d = ecode;
      end
   end

   always_ff @(posedge sdram_clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         st_q <= S_IDLE; bank_q <= '0; col_q <= '0; idx_q <= '0;
         bmask_q <= '0; ap_q <= 1'b0; open_q <= '0; row_q <= '0;
         mode_ld_q <= 1'b0; bl_mask_q <= 3'd0; cl3_q <= 1'b1;
         err_q <= 1'b0; code_q <= ERR_NONE;
         vld_pipe <= '0; dat_q <= '0; dqm_q <= '0;
      end else if (sd_cke_i) begin
         st_q <= st_d; bank_q <= bank_d; col_q <= col_d; idx_q <= idx_d;
         bmask_q <= bmask_d; ap_q <= ap_d; open_q <= open_d; row_q <= row_d;
         mode_ld_q <= mode_ld_d; bl_mask_q <= bl_mask_d; cl3_q <= cl3_d;
         err_q <= err_d; code_q <= code_d;
         // a WRITE kills read beats still in flight
         vld_pipe <= (cmd == CMD_WR) ? '0 : {vld_pipe[STAGES-1:0], rd_beat};
         if (vld_pipe[0]) dat_q[1] <= ram_rdata;
         if (vld_pipe[1]) dat_q[2] <= dat_q[1];
         dqm_q <= {dqm_q[0], dqm};
      end
   end

   // CL2 taps stage 1, CL3 stage 2; dqm_q[1] is the mask from two edges back
   assign sd_dq_o    = cl3_q ? dat_q[2] : dat_q[1];
   assign sd_dq_oe_o = {2{cl3_q ? vld_pipe[2] : vld_pipe[1]}} & ~dqm_q[1];
   assign err_o      = err_q;
   assign err_code_o = code_q;

endmodule

// File: tb/tb_sdram_responder.sv
module tb_sdram_responder;

   localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_RD  = 4'b0101,
                          C_WR  = 4'b0100, C_PRE = 4'b0010, C_MRS = 4'b0000;

   logic        clk = 1'b0, rst_n = 1'b0, cke = 1'b1;
   logic        cs = 1'b0, ras = 1'b1, cas = 1'b1, we = 1'b1;
   logic [1:0]  bs = '0;
   logic [12:0] addr = '0;
   logic        dqml = 1'b0, dqmh = 1'b0;
   logic [15:0] dq_i = '0, dq_o;
   logic [1:0]  oe;
   logic        err;
   logic [2:0]  err_code;

   int cyc = 0;
   int n_chk = 0, n_fail = 0;

   typedef struct {
      int          cyc;
      logic [1:0]  oe;
      logic [15:0] dat;
   } beat_t;
   beat_t exp_q[$];

   sdram_responder dut (
      .sdram_clk_i(clk), .rst_n_i(rst_n), .sd_cke_i(cke),
      .sd_cs_i(cs), .sd_ras_i(ras), .sd_cas_i(cas), .sd_we_i(we),
      .sd_bs_i(bs), .sd_addr_i(addr), .sd_dqml_i(dqml), .sd_dqmh_i(dqmh),
      .sd_dq_i(dq_i), .sd_dq_o(dq_o), .sd_dq_oe_o(oe),
      .err_o(err), .err_code_o(err_code)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // drive one command from a negedge; e = index of the sampling edge
   task automatic issue(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a,
                        input logic [15:0] d, input logic [1:0] m, output int e);
      {cs, ras, cas, we} = c; bs = b; addr = a; dq_i = d; {dqmh, dqml} = m;
      @(posedge clk);
      e = cyc;
      @(negedge clk);
      {cs, ras, cas, we} = C_NOP; dq_i = '0; {dqmh, dqml} = 2'b00;
   endtask

   task automatic nop(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic expect_beat(input int c, input logic [1:0] o, input logic [15:0] d);
      beat_t b;
      b.cyc = c; b.oe = o; b.dat = d;
      exp_q.push_back(b);
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // monitor: every presented beat must match the head of the scoreboard
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && oe != 2'b00) begin
            n_chk++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_beat: cyc %0d oe %b dq %h, expected none", cyc, oe, dq_o);
            end else begin
               beat_t b;
               logic [15:0] m;
               b = exp_q.pop_front();
               m = {{8{b.oe[1]}}, {8{b.oe[0]}}};
               if (cyc != b.cyc || oe != b.oe || (dq_o & m) != (b.dat & m)) begin
                  n_fail++;
                  $display("FAIL read_beat: cyc %0d oe %b dq %h, expected cyc %0d oe %b dq %h",
                           cyc, oe, dq_o, b.cyc, b.oe, b.dat);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int e, e2, dummy;
      // reset state
      nop(3);
      #1;
      chk("rst_dq", dq_o, 16'h0);
      chk("rst_oe", {14'h0, oe}, 16'h0);
      chk("rst_err", {15'h0, err}, 16'h0);
      chk("rst_code", {13'h0, err_code}, 16'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // CL2 BL1 single write / read
      issue(C_MRS, 2'd0, 13'h020, 16'h0, 2'b00, dummy);
      issue(C_ACT, 2'd1, 13'd5,   16'h0, 2'b00, dummy);
      issue(C_WR,  2'd1, 13'd3,   16'hA55A, 2'b00, dummy);
      issue(C_RD,  2'd1, 13'd3,   16'h0, 2'b00, e);
      expect_beat(e + 2, 2'b11, 16'hA55A);
      nop(4);
      chk("err_clean", {15'h0, err}, 16'h0);

      // CL3 BL4: write col6 (wraps 6,7,4,5), read col4
      issue(C_MRS, 2'd0, 13'h032, 16'h0, 2'b00, dummy);
      issue(C_WR,  2'd1, 13'd6,   16'd1, 2'b00, dummy);
      issue(C_NOP, 2'd0, 13'd0,   16'd2, 2'b00, dummy);
      issue(C_NOP, 2'd0, 13'd0,   16'd3, 2'b00, dummy);
      issue(C_NOP, 2'd0, 13'd0,   16'd4, 2'b00, dummy);
      issue(C_RD,  2'd1, 13'd4,   16'h0, 2'b00, e);
      expect_beat(e + 3, 2'b11, 16'd3);
      expect_beat(e + 4, 2'b11, 16'd4);
      expect_beat(e + 5, 2'b11, 16'd1);
      expect_beat(e + 6, 2'b11, 16'd2);
      nop(7);

      // byte masks: write mask on dqmh, read mask on dqml
      issue(C_MRS, 2'd0, 13'h020, 16'h0, 2'b00, dummy);
      issue(C_WR,  2'd1, 13'd10,  16'hFFFF, 2'b00, dummy);
      issue(C_WR,  2'd1, 13'd10,  16'h1234, 2'b10, dummy);
      issue(C_RD,  2'd1, 13'd10,  16'h0, 2'b00, e);
      expect_beat(e + 2, 2'b11, 16'hFF34);
      nop(1);
      issue(C_RD,  2'd1, 13'd10,  16'h0, 2'b01, e);
      expect_beat(e + 2, 2'b10, 16'hFF34);
      nop(4);

      // CL2 BL8: fill cols 16..23, read interrupted after 3 beats
      issue(C_MRS, 2'd0, 13'h023, 16'h0, 2'b00, dummy);
      issue(C_WR,  2'd1, 13'd16,  16'h0100, 2'b00, dummy);
      for (int i = 1; i < 8; i++)
         issue(C_NOP, 2'd0, 13'd0, 16'h0100 + 16'(i), 2'b00, dummy);
      issue(C_RD,  2'd1, 13'd16,  16'h0, 2'b00, e);
      for (int k = 0; k < 3; k++) expect_beat(e + 2 + k, 2'b11, 16'h0100 + 16'(k));
      nop(2);
      issue(C_RD,  2'd1, 13'd20,  16'h0, 2'b00, e2);
      chk("interrupt_edge", 16'(e2 - e), 16'd3);
      for (int k = 0; k < 8; k++)
         expect_beat(e2 + 2 + k, 2'b11, 16'h0100 + 16'((4 + k) % 8));
      nop(10);

      // closed bank read, then ACTIVE on an open bank keeps the first code
      issue(C_RD,  2'd2, 13'd0,   16'h0, 2'b00, dummy);
      chk("err_closed", {15'h0, err}, 16'h1);
      chk("code_closed", {13'h0, err_code}, 16'd1);
      nop(3);
      issue(C_ACT, 2'd1, 13'd7,   16'h0, 2'b00, dummy);
      chk("code_sticky", {13'h0, err_code}, 16'd1);

      // reset during a burst
      issue(C_RD,  2'd1, 13'd16,  16'h0, 2'b00, e);
      expect_beat(e + 2, 2'b11, 16'h0100);
      expect_beat(e + 3, 2'b11, 16'h0101);
      nop(2);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_dq", dq_o, 16'h0);
      chk("midrst_oe", {14'h0, oe}, 16'h0);
      chk("midrst_err", {15'h0, err}, 16'h0);
      nop(2);
      rst_n = 1'b1;
      issue(C_RD,  2'd0, 13'd0,   16'h0, 2'b00, dummy);
      chk("err_nomode", {15'h0, err}, 16'h1);
      chk("code_nomode", {13'h0, err_code}, 16'd3);
      nop(5);

      n_chk++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL missing_beats: %0d beats outstanding, expected 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

   // unused-command guard keeps PRE in the stimulus vocabulary for later use
   logic [3:0] pre_code;
   assign pre_code = C_PRE;

endmodule
